rob_param: RTL

Parametrised reorder buffer: the next generation of the core's in-order commit queue. It allocates one entry per issued instruction and accepts results from `WB_PORTS` independent writeback channels (ALU RS, LSB, …). It retires one instruction per cycle in program order and resolves both branch-direction and jump-target mispredictions at commit, producing a flush and redirect PC. It sits between the decoder/issue stage, the execution units, the register file (rename tags and commit) and the predictor/fetch redirect path.

---
 rtl/rob_param_if.sv | 63 ++++++
 rtl/rob_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param_if.sv
// Bus bundle for the reorder buffer: issue, writeback, operand query and
// commit/flush signals. The decoder/testbench side uses the master modport,
// the reorder buffer itself uses the slave modport.
interface rob_param_if #(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 2,
  parameter int XLEN     = 32
) ();
  localparam int IDX_W = $clog2(DEPTH);

  logic                      issue_valid;
  logic [6:0]                issue_type;
  logic [4:0]                issue_rd;
  logic [XLEN-1:0]           issue_pc;
  logic [XLEN-1:0]           issue_imm;
  logic [XLEN-1:0]           issue_pred_target;
  logic                      issue_pred_taken;
  logic                      full;
  logic [IDX_W-1:0]          alloc_id;
  logic [IDX_W:0]            count;

  logic [WB_PORTS-1:0]       wb_valid;
  logic [WB_PORTS*IDX_W-1:0] wb_id;
  logic [WB_PORTS*XLEN-1:0]  wb_value;
  logic [WB_PORTS*XLEN-1:0]  wb_target;
  logic [WB_PORTS-1:0]       wb_taken;

  logic [IDX_W-1:0]          q_id1;
  logic [IDX_W-1:0]          q_id2;
  logic                      q_ready1;
  logic                      q_ready2;
  logic [XLEN-1:0]           q_value1;
  logic [XLEN-1:0]           q_value2;

  logic [IDX_W-1:0]          head_id;
  logic                      commit_valid;
  logic [IDX_W-1:0]          commit_id;
  logic [4:0]                commit_rd;
  logic [XLEN-1:0]           commit_value;
  logic                      store_commit;
  logic                      flush;
  logic [XLEN-1:0]           flush_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_imm,
           issue_pred_target, issue_pred_taken,
           wb_valid, wb_id, wb_value, wb_target, wb_taken,
           q_id1, q_id2,
    input  full, alloc_id, count, q_ready1, q_ready2, q_value1, q_value2,
           head_id, commit_valid, commit_id, commit_rd, commit_value,
           store_commit, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_imm,
           issue_pred_target, issue_pred_taken,
           wb_valid, wb_id, wb_value, wb_target, wb_taken,
           q_id1, q_id2,
    output full, alloc_id, count, q_ready1, q_ready2, q_value1, q_value2,
           head_id, commit_valid, commit_id, commit_rd, commit_value,
           store_commit, flush, flush_pc
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: allocates one entry per issued instruction,
// collects results from several writeback ports, retires in program order
// and resolves branch/jump mispredictions at the head with a flush+redirect.
module rob_param #(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 2,
  parameter int XLEN     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  rob_param_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [IDX_W:0]   DEPTH_CNT = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [XLEN-1:0]  FOUR      = XLEN'(4);

  logic             ent_busy        [DEPTH];
  logic             ent_ready       [DEPTH];
  logic [6:0]       ent_type        [DEPTH];
  logic [4:0]       ent_rd          [DEPTH];
  logic [XLEN-1:0]  ent_pc          [DEPTH];
  logic [XLEN-1:0]  ent_value       [DEPTH];
  logic             ent_pred_taken  [DEPTH];
  logic [XLEN-1:0]  ent_pred_target [DEPTH];
  logic             ent_taken       [DEPTH];
  logic [XLEN-1:0]  ent_target      [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   cnt;

  logic             is_full;
  logic             do_issue;
  logic             issue_rdy;
  logic [XLEN-1:0]  issue_val;
  logic             issue_tk;
  logic [XLEN-1:0]  issue_tgt;

  logic [IDX_W-1:0] wb_idx  [WB_PORTS];
  logic [XLEN-1:0]  wb_val  [WB_PORTS];
  logic [XLEN-1:0]  wb_tgt  [WB_PORTS];
  logic             wb_tk   [WB_PORTS];
  logic             wb_live [WB_PORTS];

  logic             mispredict;
  logic             do_commit;
  logic             do_flush;
  logic [6:0]       head_type;

  logic [IDX_W-1:0] q_ids [2];
  logic             q_hit [2];
  logic [XLEN-1:0]  q_val [2];

  assign is_full   = (cnt == DEPTH_CNT);
  assign do_issue  = bus.issue_valid && !is_full && rdy;
  assign head_type = ent_type[head];
  assign do_commit = rst && rdy && ent_busy[head] && ent_ready[head];
  assign do_flush  = do_commit && mispredict;
  assign q_ids[0]  = bus.q_id1;
  assign q_ids[1]  = bus.q_id2;

  // Decide which opcode classes already know their result when issued.
  always_comb begin
    issue_rdy = 1'b0;
    issue_val = '0;
    issue_tk  = 1'b0;
    issue_tgt = '0;
    case (bus.issue_type)
      OP_LUI: begin
        issue_rdy = 1'b1;
        issue_val = bus.issue_imm;
      end
      OP_AUIPC: begin
        issue_rdy = 1'b1;
        issue_val = bus.issue_pc + bus.issue_imm;
      end
      OP_JAL: begin
        issue_rdy = 1'b1;
        issue_val = bus.issue_pc + FOUR;
        issue_tk  = 1'b1;
        issue_tgt = bus.issue_pc + bus.issue_imm;
      end
      default: ;
    endcase
  end

  // Split the packed writeback buses into one record per port.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_idx[p] = bus.wb_id[p*IDX_W +: IDX_W];
      wb_val[p] = bus.wb_value[p*XLEN +: XLEN];
      wb_tgt[p] = bus.wb_target[p*XLEN +: XLEN];
      wb_tk[p]  = bus.wb_taken[p];
    end
  end

  // A writeback only counts when enabled and aimed at an allocated entry.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_live[p] = rdy && bus.wb_valid[p] && ent_busy[wb_idx[p]];
    end
  end

  // Compare resolved direction/target of the head against its prediction.
  always_comb begin
    mispredict = 1'b0;
    case (head_type)
      OP_BRANCH: mispredict = (ent_taken[head] != ent_pred_taken[head]) ||
                              (ent_taken[head] && (ent_target[head] != ent_pred_target[head]));
      OP_JAL, OP_JALR: mispredict = (ent_target[head] != ent_pred_target[head]);
      default: mispredict = 1'b0;
    endcase
  end

  // Operand lookup: stored value, then same-cycle writeback, then issue.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      q_hit[k] = 1'b0;
      q_val[k] = '0;
      if (ent_ready[q_ids[k]]) begin
        q_hit[k] = 1'b1;
        q_val[k] = ent_value[q_ids[k]];
      end else begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_live[p] && (wb_idx[p] == q_ids[k])) begin
            q_hit[k] = 1'b1;
            q_val[k] = wb_val[p];
          end
        end
        if (!q_hit[k] && do_issue && issue_rdy && (tail == q_ids[k])) begin
          q_hit[k] = 1'b1;
          q_val[k] = issue_val;
        end
      end
    end
  end

  assign bus.full         = is_full;
  assign bus.alloc_id     = tail;
  assign bus.count        = cnt;
  assign bus.head_id      = head;
  assign bus.q_ready1     = rst && q_hit[0];
  assign bus.q_ready2     = rst && q_hit[1];
  assign bus.q_value1     = rst ? q_val[0] : '0;
  assign bus.q_value2     = rst ? q_val[1] : '0;
  assign bus.commit_valid = do_commit;
  assign bus.commit_id    = do_commit ? head : '0;
  assign bus.commit_rd    = (do_commit && (head_type != OP_BRANCH) && (head_type != OP_STORE))
                            ? ent_rd[head] : 5'd0;
  assign bus.commit_value = !do_commit ? '0 :
                            ((head_type == OP_JAL) || (head_type == OP_JALR))
                            ? (ent_pc[head] + FOUR) : ent_value[head];
  assign bus.store_commit = do_commit && (head_type == OP_STORE);
  assign bus.flush        = do_flush;
  assign bus.flush_pc     = !do_flush ? '0 :
                            ent_taken[head] ? ent_target[head] : (ent_pc[head] + FOUR);

  // Entry storage and pointers; flush beats issue/writeback, commit beats writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_busy[i]        <= 1'b0;
        ent_ready[i]       <= 1'b0;
        ent_type[i]        <= '0;
        ent_rd[i]          <= '0;
        ent_pc[i]          <= '0;
        ent_value[i]       <= '0;
        ent_pred_taken[i]  <= 1'b0;
        ent_pred_target[i] <= '0;
        ent_taken[i]       <= 1'b0;
        ent_target[i]      <= '0;
      end
    end else if (rdy) begin
      if (do_flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ent_busy[i]  <= 1'b0;
          ent_ready[i] <= 1'b0;
        end
      end else begin
        if (do_issue) begin
          ent_busy[tail]        <= 1'b1;
          ent_ready[tail]       <= issue_rdy;
          ent_type[tail]        <= bus.issue_type;
          ent_rd[tail]          <= bus.issue_rd;
          ent_pc[tail]          <= bus.issue_pc;
          ent_value[tail]       <= issue_val;
          ent_pred_taken[tail]  <= bus.issue_pred_taken;
          ent_pred_target[tail] <= bus.issue_pred_target;
          ent_taken[tail]       <= issue_tk;
          ent_target[tail]      <= issue_tgt;
          tail                  <= tail + IDX_ONE;
        end
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_live[p]) begin
            ent_ready[wb_idx[p]]  <= 1'b1;
            ent_value[wb_idx[p]]  <= wb_val[p];
            ent_taken[wb_idx[p]]  <= wb_tk[p];
            ent_target[wb_idx[p]] <= wb_tgt[p];
          end
        end
        if (do_commit) begin
          ent_busy[head]  <= 1'b0;
          ent_ready[head] <= 1'b0;
          head            <= head + IDX_ONE;
        end
        case ({do_issue, do_commit})
          2'b10:   cnt <= cnt + CNT_ONE;
          2'b01:   cnt <= cnt - CNT_ONE;
          default: cnt <= cnt;
        endcase
      end
    end
  end
endmodule
